// File: rtl/mips_fwd_mux_reg_if.sv
// Operand-forwarding bus: flattened source operands and control toward the mux,
// and the registered operand, valid bit and forwarding statistics returned.
interface mips_fwd_mux_reg_if #(
  parameter int SIZE       = 32,
  parameter int NUM_INPUTS = 3,
  parameter int SEL_W      = 2,
  parameter int CNT_W      = 16
);
  logic [NUM_INPUTS*SIZE-1:0] Inputs;
  logic [SEL_W-1:0]           ControlSignal;
  logic                       InValid;
  logic                       Stall;
  logic                       Flush;
  logic                       CountClr;
  logic [SIZE-1:0]            Output;
  logic                       OutValid;
  logic [CNT_W-1:0]           FwdCount;
  logic                       SelError;

  modport master (
    output Inputs, ControlSignal, InValid, Stall, Flush, CountClr,
    input  Output, OutValid, FwdCount, SelError
  );

  modport slave (
    input  Inputs, ControlSignal, InValid, Stall, Flush, CountClr,
    output Output, OutValid, FwdCount, SelError
  );
endinterface

// File: rtl/mips_fwd_mux_reg.sv
// N:1 EX-stage operand-forwarding mux, 1-cycle registered; Stall holds, Flush bubbles.
// Optional sticky illegal-select flag built only with MIPS_FWD_SEL_CHECK_EN defined.
module mips_fwd_mux_reg #(
  parameter int SIZE       = 32,
  parameter int NUM_INPUTS = 3,
  parameter int SEL_W      = 2,
  parameter int CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  mips_fwd_mux_reg_if.slave bus
);

  localparam logic [31:0] NUM_IN_U = 32'(NUM_INPUTS);

  logic [31:0]      sel_ext;
  logic             sel_legal;
  logic             sel_fwd;
  logic             accept;
  logic [SIZE-1:0]  sel_dat;

  logic [SIZE-1:0]  out_q, out_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign sel_ext   = 32'(bus.ControlSignal);
  assign sel_legal = sel_ext < NUM_IN_U;
  assign sel_fwd   = sel_legal && (sel_ext != 32'd0);
  assign accept    = bus.InValid && !bus.Stall && !bus.Flush;

  // Out-of-range selects fall back to the register-file path (source 0).
  always_comb begin
    sel_dat = bus.Inputs[0 +: SIZE];
    for (int k = 1; k < NUM_INPUTS; k++) begin
      if (sel_ext == 32'(k)) begin
        sel_dat = bus.Inputs[k*SIZE +: SIZE];
      end
    end
  end

  always_comb begin
    out_d = out_q;
    vld_d = vld_q;
    if (bus.Flush) begin
      out_d = '0;
      vld_d = 1'b0;
    end else if (!bus.Stall) begin
      out_d = sel_dat;
      vld_d = bus.InValid;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.CountClr) begin
      cnt_d = '0;
    end else if (accept && sel_fwd && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_q <= '0;
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.Output   = out_q;
  assign bus.OutValid = vld_q;
  assign bus.FwdCount = cnt_q;

`ifdef MIPS_FWD_SEL_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (bus.CountClr) begin
      err_d = 1'b0;
    end else if (accept && !sel_legal) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.SelError = err_q;
`else
  assign bus.SelError = 1'b0;
`endif

endmodule

// File: tb/tb_mips_fwd_mux_reg.sv
// Scoreboard bench for mips_fwd_mux_reg: directed scenarios plus random traffic
// against a behavioural model; a separate monitor compares every registered output.
module tb_mips_fwd_mux_reg;

  localparam int SIZE = 32;
  localparam int NI   = 3;
  localparam int SW   = 2;
  localparam int CW   = 4;

  logic Clk;
  logic Reset_n;

  mips_fwd_mux_reg_if #(.SIZE(SIZE), .NUM_INPUTS(NI), .SEL_W(SW), .CNT_W(CW)) bus ();

  mips_fwd_mux_reg #(.SIZE(SIZE), .NUM_INPUTS(NI), .SEL_W(SW), .CNT_W(CW)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] out;
    logic        vld;
    logic [3:0]  cnt;
    logic        err;
    int          idx;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_no  = 0;

  // Behavioural model state
  logic [31:0] m_out;
  logic        m_vld;
  int          m_cnt;
  logic        m_err;

  task automatic cmp(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h exp=%h", name, idx, got, exp);
    end
  endtask

  task automatic model_reset();
    m_out = '0;
    m_vld = 1'b0;
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, "_out"}, step_no, bus.Output, 32'd0);
    cmp({tag, "_vld"}, step_no, 32'(bus.OutValid), 32'd0);
    cmp({tag, "_cnt"}, step_no, 32'(bus.FwdCount), 32'd0);
    cmp({tag, "_err"}, step_no, 32'(bus.SelError), 32'd0);
  endtask

  // Drive one cycle of stimulus and push the outcome expected after the next edge.
  task automatic step(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
                      input int sel, input logic inv, input logic stall,
                      input logic flush, input logic clr);
    logic [31:0] src [3];
    logic        acc;
    exp_t        e;
    @(negedge Clk);
    bus.Inputs        = {s2, s1, s0};
    bus.ControlSignal = SW'(sel);
    bus.InValid       = inv;
    bus.Stall         = stall;
    bus.Flush         = flush;
    bus.CountClr      = clr;
    src[0] = s0; src[1] = s1; src[2] = s2;
    acc = inv && !stall && !flush;
    if (clr) m_cnt = 0;
    else if (acc && sel >= 1 && sel < NI && m_cnt < 15) m_cnt = m_cnt + 1;
`ifdef MIPS_FWD_SEL_CHECK_EN
    if (clr) m_err = 1'b0;
    else if (acc && sel >= NI) m_err = 1'b1;
`endif
    if (flush) begin
      m_out = '0;
      m_vld = 1'b0;
    end else if (!stall) begin
      m_out = (sel < NI) ? src[sel] : src[0];
      m_vld = inv;
    end
    step_no++;
    e.out = m_out; e.vld = m_vld; e.cnt = 4'(m_cnt); e.err = m_err; e.idx = step_no;
    sbq.push_back(e);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset(input string tag);
    @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1 check_zero(tag);
    model_reset();
    #1 Reset_n = 1'b1;
  endtask

  always begin
    exp_t e;
    @(posedge Clk);
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      cmp("out", e.idx, bus.Output, e.out);
      cmp("vld", e.idx, 32'(bus.OutValid), 32'(e.vld));
      cmp("cnt", e.idx, 32'(bus.FwdCount), 32'(e.cnt));
      cmp("err", e.idx, 32'(bus.SelError), 32'(e.err));
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    Reset_n           = 1'b0;
    bus.Inputs        = '0;
    bus.ControlSignal = '0;
    bus.InValid       = 1'b0;
    bus.Stall         = 1'b0;
    bus.Flush         = 1'b0;
    bus.CountClr      = 1'b0;
    model_reset();
    #2 check_zero("rst");
    #1 Reset_n = 1'b1;

    // Select sweep
    for (int s = 0; s < 3; s++)
      step(32'h11111111, 32'h22222222, 32'h33333333, s, 1'b1, 1'b0, 1'b0, 1'b0);
    // Illegal select falls back to source 0, then clear
    step(32'h11111111, 32'h22222222, 32'h33333333, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h11111111, 32'h22222222, 32'h33333333, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Load, then stall three cycles with changing inputs
    step(32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step($urandom, $urandom, $urandom, 2, 1'b1, 1'b1, 1'b0, 1'b0);
    // Flush together with stall while valid
    step(32'h1, 32'h2, 32'h3, 1, 1'b1, 1'b1, 1'b1, 1'b0);
    // InValid low still loads data with OutValid low
    step(32'hDEADBEEF, 32'h2, 32'h3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Saturation
    for (int i = 0; i < 20; i++)
      step($urandom, $urandom, $urandom, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h5, 32'h6, 32'h7, 1, 1'b1, 1'b0, 1'b0, 1'b1);
    // Async reset in the middle of a stall
    step(32'h55555555, 32'h66666666, 32'h77777777, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h0, 32'h0, 32'h0, 1, 1'b1, 1'b1, 1'b0, 1'b0);
    pulse_reset("arst");
    step(32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 2, 1'b1, 1'b0, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom, $urandom, $urandom, int'($urandom_range(0, 3)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 19) == 0));
      if (i == 200) pulse_reset("arst2");
    end

    repeat (2) @(posedge Clk);
    #2;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
